// File: rtl/cache_hmem_arbiter.sv
// cache_hmem_arbiter
// Arbitrates one downstream higher-memory port between the I-cache (port 0)
// and the D-cache (port 1). A grant locks onto one requester for a whole
// cache line (WORDS_PER_LINE word transfers) or until that requester drops
// valid, then returns to IDLE for at least one cycle. Ties are broken
// round-robin against the last served port.
//
// Ports
//   clk, reset                 : clock, async active-high reset
//   pN_req_valid/store/address/store_word : requester N word request
//   pN_req_fulfilled           : transfer-complete pulse to requester N
//   req_loaded_word            : load data, broadcast to both requesters
//   mem_req_valid/store/address/store_word : downstream request
//   mem_req_fulfilled, mem_req_loaded_word : downstream completion / data
//   grant                      : one-hot owner (bit0 = port 0), 00 when idle
module cache_hmem_arbiter #(
  parameter int XLEN      = 32,
  parameter int LINE_SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p0_req_valid,
  input  logic            p0_req_store,
  input  logic [XLEN-1:0] p0_req_address,
  input  logic [XLEN-1:0] p0_req_store_word,
  output logic            p0_req_fulfilled,
  input  logic            p1_req_valid,
  input  logic            p1_req_store,
  input  logic [XLEN-1:0] p1_req_address,
  input  logic [XLEN-1:0] p1_req_store_word,
  output logic            p1_req_fulfilled,
  output logic [XLEN-1:0] req_loaded_word,
  output logic            mem_req_valid,
  output logic            mem_req_store,
  output logic [XLEN-1:0] mem_req_address,
  output logic [XLEN-1:0] mem_req_store_word,
  input  logic            mem_req_fulfilled,
  input  logic [XLEN-1:0] mem_req_loaded_word,
  output logic [1:0]      grant
);

  localparam int WORDS_PER_LINE = LINE_SIZE / 4;
  localparam int CW             = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS_PER_LINE - 1);

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("cache_hmem_arbiter: only XLEN=32 is supported");
    end
    if ((LINE_SIZE % 4) != 0 || LINE_SIZE < 4) begin : g_bad_line
      $error("cache_hmem_arbiter: LINE_SIZE must be a positive multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic            valid;
    logic            store;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] store_word;
  } req_t;

  req_t [1:0] req;
  assign req[0] = '{p0_req_valid, p0_req_store, p0_req_address, p0_req_store_word};
  assign req[1] = '{p1_req_valid, p1_req_store, p1_req_address, p1_req_store_word};

  state_t        state, state_next;
  logic [CW-1:0] beat, beat_next;
  logic          last_served, last_next;  // 1 = port 1 was served last
  logic          own;                     // index of the owning port in OWNn

  assign own             = (state == OWN1);
  assign req_loaded_word = mem_req_loaded_word;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      last_served <= 1'b1;
    end else begin
      state       <= state_next;
      beat        <= beat_next;
      last_served <= last_next;
    end
  end

  // Next-state: IDLE only looks at registered state, so the grant (and hence
  // mem_req_valid) always lags requester valid by one cycle.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    last_next  = last_served;
    unique case (state)
      IDLE: begin
        beat_next = '0;
        if (p0_req_valid && p1_req_valid) state_next = last_served ? OWN0 : OWN1;
        else if (p0_req_valid)            state_next = OWN0;
        else if (p1_req_valid)            state_next = OWN1;
      end
      OWN0, OWN1: begin
        if (!req[own].valid || (mem_req_fulfilled && beat == LAST_BEAT)) begin
          // abort or line complete: release, wrap counter, remember owner
          state_next = IDLE;
          beat_next  = '0;
          last_next  = own;
        end else if (mem_req_fulfilled) begin
          beat_next = beat + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Outputs: owner's request passed straight through, completion routed back
  always_comb begin
    grant              = 2'b00;
    mem_req_valid      = 1'b0;
    mem_req_store      = 1'b0;
    mem_req_address    = '0;
    mem_req_store_word = '0;
    p0_req_fulfilled   = 1'b0;
    p1_req_fulfilled   = 1'b0;
    if (state == OWN0 || state == OWN1) begin
      grant[own]         = 1'b1;
      mem_req_valid      = req[own].valid;
      mem_req_store      = req[own].store;
      mem_req_address    = req[own].address;
      mem_req_store_word = req[own].store_word;
      p0_req_fulfilled   = mem_req_fulfilled & ~own;
      p1_req_fulfilled   = mem_req_fulfilled &  own;
    end
  end

endmodule

// File: tb/tb_cache_hmem_arbiter.sv
// Directed bench for cache_hmem_arbiter: the bench plays both requesters and
// a downstream memory that completes each word two cycles after it appears.
module tb_cache_hmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_valid, p0_req_store, p0_req_fulfilled;
  logic [31:0] p0_req_address, p0_req_store_word;
  logic        p1_req_valid, p1_req_store, p1_req_fulfilled;
  logic [31:0] p1_req_address, p1_req_store_word;
  logic [31:0] req_loaded_word;
  logic        mem_req_valid, mem_req_store, mem_req_fulfilled;
  logic [31:0] mem_req_address, mem_req_store_word, mem_req_loaded_word;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;
  int pulses;

  cache_hmem_arbiter #(.XLEN(32), .LINE_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_store(p0_req_store),
    .p0_req_address(p0_req_address), .p0_req_store_word(p0_req_store_word),
    .p0_req_fulfilled(p0_req_fulfilled),
    .p1_req_valid(p1_req_valid), .p1_req_store(p1_req_store),
    .p1_req_address(p1_req_address), .p1_req_store_word(p1_req_store_word),
    .p1_req_fulfilled(p1_req_fulfilled),
    .req_loaded_word(req_loaded_word),
    .mem_req_valid(mem_req_valid), .mem_req_store(mem_req_store),
    .mem_req_address(mem_req_address), .mem_req_store_word(mem_req_store_word),
    .mem_req_fulfilled(mem_req_fulfilled), .mem_req_loaded_word(mem_req_loaded_word),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_mvalid"}, 32'(mem_req_valid), 0);
    chk({tag, "_f0"}, 32'(p0_req_fulfilled), 0);
    chk({tag, "_f1"}, 32'(p1_req_fulfilled), 0);
  endtask

  // Run nbeats word transfers for port n, which must already own the bus.
  // Returns at #1 after the edge that accepted the last fulfilled beat.
  task automatic serve(input int n, input logic [31:0] base, input int nbeats,
                       output int npulse);
    logic [31:0] g;
    logic [31:0] a;
    logic        fown, foth;
    g = (n == 0) ? 32'd1 : 32'd2;
    npulse = 0;
    for (int k = 0; k < nbeats; k++) begin
      a = base + 32'(4 * k);
      if (n == 0) p0_req_address = a; else p1_req_address = a;
      for (int w = 0; w < 2; w++) begin
        #1;
        chk("wait_valid", 32'(mem_req_valid), 1);
        chk("wait_addr", mem_req_address, a);
        chk("wait_grant", 32'(grant), g);
        chk("wait_f0", 32'(p0_req_fulfilled), 0);
        chk("wait_f1", 32'(p1_req_fulfilled), 0);
        tick();
      end
      mem_req_fulfilled   = 1'b1;
      mem_req_loaded_word = 32'hA5A5_0000 + 32'(k);
      #1;
      fown = (n == 0) ? p0_req_fulfilled : p1_req_fulfilled;
      foth = (n == 0) ? p1_req_fulfilled : p0_req_fulfilled;
      chk("beat_loaded", req_loaded_word, 32'hA5A5_0000 + 32'(k));
      chk("beat_grant", 32'(grant), g);
      chk("beat_fown", 32'(fown), 1);
      chk("beat_fother", 32'(foth), 0);
      if (fown === 1'b1) npulse++;
      tick();
      mem_req_fulfilled = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    p0_req_valid = 0; p0_req_store = 0; p0_req_address = '0; p0_req_store_word = '0;
    p1_req_valid = 0; p1_req_store = 0; p1_req_address = '0; p1_req_store_word = '0;
    mem_req_fulfilled = 0; mem_req_loaded_word = '0;
    #1;
    idle_checks("reset");
    tick(); tick();
    reset = 1'b0;

    // single port line, no same-cycle grant
    p0_req_valid = 1; p0_req_address = 32'h100;
    #1;
    idle_checks("p0_sampled");
    tick();
    serve(0, 32'h100, 8, pulses);
    chk("single_pulses", 32'(pulses), 8);
    p0_req_valid = 0;
    mem_req_fulfilled = 1;            // stray completion while idle
    #1;
    idle_checks("stray_idle");
    tick();
    mem_req_fulfilled = 0;
    #1;
    idle_checks("after_stray");

    // tie after reset: port 0 first, one idle bubble, then port 1
    reset = 1; #1; tick(); reset = 0;
    p0_req_valid = 1; p0_req_address = 32'h300;
    p1_req_valid = 1; p1_req_address = 32'h400;
    #1;
    chk("tie_idle_grant", 32'(grant), 0);
    tick();
    serve(0, 32'h300, 8, pulses);
    chk("tie_p0_pulses", 32'(pulses), 8);
    p0_req_valid = 0;
    #1;
    idle_checks("tie_bubble");
    tick();
    serve(1, 32'h400, 8, pulses);
    chk("tie_p1_pulses", 32'(pulses), 8);

    // round robin: p1 just served, both valid -> p0
    p0_req_valid = 1; p0_req_address = 32'h500;
    #1;
    chk("rr_idle_grant", 32'(grant), 0);
    tick();
    chk("rr_grant", 32'(grant), 1);
    serve(0, 32'h500, 8, pulses);
    chk("rr_pulses", 32'(pulses), 8);
    p0_req_valid = 0;

    // store passthrough on port 1
    p1_req_store = 1; p1_req_address = 32'h2000; p1_req_store_word = 32'hDEADBEEF;
    #1;
    chk("st_idle_grant", 32'(grant), 0);
    tick();
    #1;
    chk("st_grant", 32'(grant), 2);
    chk("st_store", 32'(mem_req_store), 1);
    chk("st_addr", mem_req_address, 32'h2000);
    chk("st_data", mem_req_store_word, 32'hDEADBEEF);
    serve(1, 32'h2000, 8, pulses);
    chk("st_pulses", 32'(pulses), 8);
    p1_req_valid = 0; p1_req_store = 0;

    // abort: p0 drops after 3 beats, pending p1 follows
    p0_req_valid = 1; p0_req_address = 32'h600;
    p1_req_valid = 1; p1_req_address = 32'h700;
    #1;
    chk("ab_idle_grant", 32'(grant), 0);
    tick();
    serve(0, 32'h600, 3, pulses);
    chk("ab_p0_pulses", 32'(pulses), 3);
    p0_req_valid = 0;
    #1;
    chk("ab_drop_grant", 32'(grant), 1);
    chk("ab_drop_mvalid", 32'(mem_req_valid), 0);
    chk("ab_drop_f1", 32'(p1_req_fulfilled), 0);
    tick();
    #1;
    idle_checks("ab_idle");
    tick();
    chk("ab_p1_grant", 32'(grant), 2);
    serve(1, 32'h700, 8, pulses);
    chk("ab_p1_pulses", 32'(pulses), 8);

    // reset in the middle of beat 4 of an OWN1 line
    p1_req_address = 32'h800;
    tick();
    serve(1, 32'h800, 3, pulses);
    p1_req_address = 32'h80C;
    mem_req_fulfilled = 1;
    #1;
    chk("rst_beat4_f1", 32'(p1_req_fulfilled), 1);
    reset = 1;
    #1;
    idle_checks("rst_async");
    tick();
    mem_req_fulfilled = 0;
    #1;
    idle_checks("rst_held");
    reset = 0;
    tick();
    serve(1, 32'h800, 8, pulses);
    chk("rst_fresh_pulses", 32'(pulses), 8);
    p1_req_valid = 0;
    #1;
    idle_checks("end_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_hmem_arbiter.md
CACHE_HMEM_ARBITER -- requirements
Module: cache_hmem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/data width; only 32 supported, elaboration error otherwise.
REQ-002 SHALL have parameter LINE_SIZE, default 32: bytes per cache line; must be a multiple of 4, elaboration error otherwise; WORDS_PER_LINE = LINE_SIZE/4.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports p0_req_valid / p1_req_valid, input, 1 each: requester 0 (I-cache) and requester 1 (D-cache) higher-memory request valid.
REQ-006 SHALL have ports p0_req_store / p1_req_store, input, 1 each: 1 = word store, 0 = word load.
REQ-007 SHALL have ports p0_req_address / p1_req_address, input, XLEN each: word-aligned address.
REQ-008 SHALL have ports p0_req_store_word / p1_req_store_word, input, XLEN each: store data.
REQ-009 SHALL have ports p0_req_fulfilled / p1_req_fulfilled, output, 1 each: transfer-complete pulse to that requester.
REQ-010 SHALL have port req_loaded_word, output, XLEN: load data, broadcast to both requesters.
REQ-011 SHALL have ports mem_req_valid (out, 1), mem_req_store (out, 1), mem_req_address (out, XLEN), mem_req_store_word (out, XLEN): downstream memory request.
REQ-012 SHALL have ports mem_req_fulfilled (in, 1) and mem_req_loaded_word (in, XLEN): downstream completion and load data.
REQ-013 SHALL have port grant, output, 2: one-hot owner, bit0 = requester 0, bit1 = requester 1; 2'b00 when idle.

Function
REQ-014 SHALL implement states IDLE, OWN0, OWN1.
REQ-015 Protocol: a requester holds valid, address, store and data stable from assertion until the cycle its fulfilled is high; the downstream memory follows the same rule.
REQ-016 In IDLE: mem_req_valid=0, both fulfilled=0, grant=00.
REQ-017 IDLE transitions: only p0 valid -> OWN0; only p1 valid -> OWN1; both valid -> the port not recorded in last_served; neither -> stay IDLE.
REQ-018 Latency: the first mem_req_valid appears one cycle after requester valid is sampled in IDLE; no combinational path exists from requester valid to mem_req_valid while in IDLE.
REQ-019 In OWNn: the mem_req_* outputs are combinationally driven from port n; mem_req_fulfilled is routed to pn_req_fulfilled in the same cycle; the other port's fulfilled is 0.
REQ-020 req_loaded_word SHALL equal mem_req_loaded_word in every cycle.
REQ-021 Beat counter, width clog2(WORDS_PER_LINE) with minimum 1: cleared in IDLE; incremented on each mem_req_fulfilled in OWNn.
REQ-022 Line lock: OWNn SHALL be held until WORDS_PER_LINE transfers are fulfilled; on the fulfilled that completes the line -> IDLE, counter cleared, last_served=n.
REQ-023 Abort: in OWNn, when pn_req_valid=0 (no transfer outstanding by protocol) -> IDLE next cycle, counter cleared, last_served=n.
REQ-024 The other port's valid during OWNn SHALL be ignored; it stays pending, with no fulfilled, until granted.
REQ-025 After IDLE the arbiter SHALL spend at least one cycle in IDLE before a new grant; back-to-back lines therefore incur a one-cycle bubble.
REQ-026 Counter wrap: the counter SHALL wrap to 0 after the final beat; it never exceeds WORDS_PER_LINE-1.
REQ-027 Fulfilled received in IDLE SHALL be ignored; no fulfilled pulse SHALL be generated from it.

Reset
REQ-028 Reset SHALL asynchronously force state=IDLE, counter=0, last_served=1 (port 0 wins the first tie), and grant=00, mem_req_valid=0, and both fulfilled=0 immediately.
REQ-029 Reset mid-line SHALL abandon the line without any further fulfilled pulse; arbitration restarts from IDLE on the first edge after deassertion.

Verification
REQ-030 Single port: p0 valid, store=0, addr 0x100, memory fulfils each beat after 2 cycles -> grant=01 one cycle later; addresses 0x100..0x11C are passed through; 8 p0 fulfilled pulses occur; then IDLE, grant=00.
REQ-031 Tie after reset: p0 and p1 valid in the same cycle -> OWN0 first; after 8 beats, one IDLE cycle, then OWN1 for 8 beats.
REQ-032 Round robin: p1 line served, then both valid -> p0 granted; p1 never sees fulfilled during OWN0.
REQ-033 Store passthrough: p1 store, addr 0x2000, data 0xDEADBEEF -> mem_req_store=1 with matching address and data on the same cycle as grant.
REQ-034 Abort: p0 drops valid after 3 fulfilled beats -> IDLE next cycle, counter=0; a pending p1 is granted on the following cycle.
REQ-035 Reset at beat 4 of OWN1 -> mem_req_valid, grant and fulfilled go to 0 without waiting for a clock; after release, a p1 request starts a fresh 8-beat line.
